spi_flash_word_reader: RTL and testbench
========================================

// Module: spi_flash_word_reader
// PURPOSE
//  Serves 32-bit word reads for the boot ROM window out of a serial NOR flash,
//  using SPI mode 0 and the standard READ command (0x03).
//  Sits between the bus-cycle controller and the flash pins.
//  - The controller pulses rom_stb with a word address.
//  - This block returns the word with a one-cycle rom_ack.
//  - Sequential word reads continue the open flash stream, so no command or
//    address is re-sent for them.
// PARAMETERS
//  CLK_DIV    2      clk cycles per SCK half-period (>=1)
//  WAKE_WAIT  1024   clk cycles to wait after release-from-power-down (0xAB)
//  CS_HIGH    8      minimum clk cycles spi_ss stays high between commands
//  STREAM_EN  1      1 = keep CS low and stream sequential words; 0 = always re-command
// PORTS
//  clk        in   1   system clock
//  rst        in   1   asynchronous reset, active low
//  rom_stb    in   1   one-cycle request pulse; rom_addr valid in the same cycle
//  rom_addr   in   22  word address; flash byte address = {rom_addr,2'b00}
//  rom_ack    out  1   one-cycle pulse; rom_odata valid in the same cycle and held until the next ack
//  rom_odata  out  32  read word, big-endian: first flash byte goes to [31:24]
//  rom_ready  out  1   high once the wake-up sequence has completed
//  spi_ss     out  1   flash chip select, active low
//  spi_sck    out  1   SPI clock, idles low
//  spi_mosi   out  1   serial data to flash, MSB first
//  spi_miso   in   1   serial data from flash
//  spi_io2    out  1   WP#, constant 1
//  spi_io3    out  1   HOLD#, constant 1
// BEHAVIOUR
//  Reset values (async, rst=0):
//   - spi_ss=1, spi_sck=0, spi_mosi=0, rom_ack=0, rom_odata=0, rom_ready=0.
//   - State is WAKE_CMD. All counters are cleared.
//  Bit timing:
//   - Each bit takes 2*CLK_DIV clk cycles.
//   - mosi is updated while sck is low; sck rises after CLK_DIV cycles.
//   - miso is sampled on the clk edge that raises sck.
//   - sck falls after a further CLK_DIV cycles.
//  States:
//   - WAKE_CMD: ss low; shift 8'hAB; then ss high -> WAKE_HOLD.
//   - WAKE_HOLD: count WAKE_WAIT cycles; then rom_ready=1 -> IDLE.
//   - IDLE: ss high. On rom_stb, latch rom_addr into cur_addr.
//     If the CS_HIGH hold count has expired -> CMD; otherwise wait for it, then CMD.
//   - CMD: shift 8'h03 -> ADDR.
//   - ADDR: shift the 24-bit {cur_addr,2'b00} MSB first -> DATA.
//   - DATA: shift in 32 bits -> ACK.
//   - ACK: one cycle; drive rom_odata=shift reg and rom_ack=1.
//     Then -> STREAM (STREAM_EN=1), or ss high, CS_HIGH count restarts -> IDLE.
//   - STREAM: ss stays low, sck low. On rom_stb:
//     - hit (rom_addr == cur_addr+1, no 22-bit carry out): latch, -> DATA;
//     - miss: latch, raise ss, run the CS_HIGH hold, -> CMD.
//  Handshake:
//   - rom_stb is accepted only in IDLE and STREAM. Pulses in any other state,
//     including during wake, are dropped with no ack.
//   - Exactly one rom_ack per accepted request.
//  Latency (CLK_DIV=2, from the stb cycle to the ack cycle):
//   - cold read: 64 bits*4 = 256 cycles + hold/entry overhead, <= 270.
//   - stream hit: 128 + <=3 cycles.
//  Boundaries:
//   - cur_addr = 22'h3FFFFF followed by a request for 0 is a miss (no wrap streaming).
//   - A request for the same address again is a miss.
//   - rom_stb coincident with the ACK cycle is dropped.
//   - Reset during any state forces ss high and sck low immediately.
//     No ack is issued for the in-flight read; wake restarts.
//   - rom_odata changes only in the ACK cycle.
// TESTING
//  1. Release rst -> mosi shows 0xAB with ss low for 8 SCK; ss high;
//     rom_ready rises after 1024 cycles; an earlier stb gets no ack.
//  2. stb, rom_addr=22'h040000; model returns DE AD BE EF ->
//     mosi 03 10 00 00; one ack with rom_odata=32'hDEADBEEF; ss stays low.
//  3. Follow with stb, rom_addr=22'h040001; model returns 01 23 45 67 ->
//     no command bytes; exactly 32 SCKs; rom_odata=32'h01234567.
//  4. Then stb, rom_addr=22'h000010 -> ss high >= 8 cycles; new 03 00 00 40 sequence.
//  5. stb at cur_addr=22'h3FFFFF then 22'h000000 -> treated as a miss (re-command);
//     stb pulses during DATA are ignored (ack count = accepted count).
//  6. Assert rst mid-DATA -> ss=1 and sck=0 in the same cycle; no ack;
//     the 0xAB wake sequence repeats after release.

Source files
------------

// File: rtl/spi_flash_word_reader.sv
// Boot-ROM word reader for a serial NOR flash: SPI mode 0, READ (0x03), with
// sequential-word streaming that keeps the flash read open between hits.
module spi_flash_word_reader #(
  parameter int unsigned CLK_DIV   = 2,
  parameter int unsigned WAKE_WAIT = 1024,
  parameter int unsigned CS_HIGH   = 8,
  parameter bit          STREAM_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rom_stb,
  input  logic [21:0] rom_addr,
  output logic        rom_ack,
  output logic [31:0] rom_odata,
  output logic        rom_ready,
  output logic        spi_ss,
  output logic        spi_sck,
  output logic        spi_mosi,
  input  logic        spi_miso,
  output logic        spi_io2,
  output logic        spi_io3
);

  typedef enum logic [3:0] {
    StWakeCmd, StWakeHold, StIdle, StHold, StCmd, StAddr, StData, StAck, StStream
  } state_e;

  localparam logic [15:0] DivMax   = 16'(CLK_DIV - 1);
  localparam logic [15:0] HoldMax  = 16'(CS_HIGH);
  localparam logic [31:0] WakeMax  = 32'(WAKE_WAIT);
  localparam logic [31:0] WakeWord = 32'hAB00_0000;

  state_e      state;
  logic [15:0] div_cnt;
  logic [15:0] hold_cnt;
  logic [31:0] wake_cnt;
  logic [30:0] tx;
  logic [31:0] rx;
  logic [5:0]  bit_cnt;
  logic [21:0] cur_addr;

  logic        shifting, tick, sck_fall, hold_done, hit;
  logic [31:0] cmd_word;

  assign spi_io2 = 1'b1;
  assign spi_io3 = 1'b1;

  always_comb begin
    shifting  = (state == StWakeCmd && !spi_ss) || state == StCmd || state == StAddr ||
                state == StData;
    tick      = shifting && (div_cnt == DivMax);
    sck_fall  = tick && spi_sck;
    hold_done = hold_cnt == HoldMax;
    // A hit must not rely on a 22-bit wrap from the top word back to zero.
    hit       = ({1'b0, cur_addr} + 23'd1) == {1'b0, rom_addr};
    cmd_word  = {8'h03, (state == StIdle) ? rom_addr : cur_addr, 2'b00};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= StWakeCmd;
      spi_ss    <= 1'b1;
      spi_sck   <= 1'b0;
      spi_mosi  <= 1'b0;
      rom_ack   <= 1'b0;
      rom_odata <= '0;
      rom_ready <= 1'b0;
      div_cnt   <= '0;
      hold_cnt  <= '0;
      wake_cnt  <= '0;
      tx        <= '0;
      rx        <= '0;
      bit_cnt   <= '0;
      cur_addr  <= '0;
    end else begin
      rom_ack <= 1'b0;

      // Counts clk cycles with ss high; cleared whenever the flash is selected.
      if (!spi_ss) hold_cnt <= '0;
      else if (!hold_done) hold_cnt <= hold_cnt + 16'd1;

      if (shifting) begin
        if (tick) begin
          div_cnt <= '0;
          spi_sck <= ~spi_sck;
          if (!spi_sck) rx <= {rx[30:0], spi_miso};
        end else begin
          div_cnt <= div_cnt + 16'd1;
        end
      end

      // Non-final falling edges advance mosi to the next bit.
      if (sck_fall) begin
        bit_cnt  <= bit_cnt + 6'd1;
        spi_mosi <= tx[30];
        tx       <= {tx[29:0], 1'b0};
      end

      unique case (state)
        StWakeCmd: begin
          if (spi_ss) begin
            spi_ss   <= 1'b0;
            spi_mosi <= WakeWord[31];
            tx       <= WakeWord[30:0];
            bit_cnt  <= '0;
          end else if (sck_fall && bit_cnt == 6'd7) begin
            spi_ss   <= 1'b1;
            spi_mosi <= 1'b0;
            wake_cnt <= '0;
            state    <= StWakeHold;
          end
        end
        StWakeHold: begin
          wake_cnt <= wake_cnt + 32'd1;
          if (wake_cnt + 32'd1 >= WakeMax) begin
            rom_ready <= 1'b1;
            state     <= StIdle;
          end
        end
        StIdle: begin
          if (rom_stb) begin
            cur_addr <= rom_addr;
            if (hold_done) begin
              spi_ss   <= 1'b0;
              spi_mosi <= cmd_word[31];
              tx       <= cmd_word[30:0];
              bit_cnt  <= '0;
              state    <= StCmd;
            end else begin
              state <= StHold;
            end
          end
        end
        StHold: begin
          if (hold_done) begin
            spi_ss   <= 1'b0;
            spi_mosi <= cmd_word[31];
            tx       <= cmd_word[30:0];
            bit_cnt  <= '0;
            state    <= StCmd;
          end
        end
        StCmd: begin
          if (sck_fall && bit_cnt == 6'd7) begin
            bit_cnt <= '0;
            state   <= StAddr;
          end
        end
        StAddr: begin
          if (sck_fall && bit_cnt == 6'd23) begin
            bit_cnt  <= '0;
            spi_mosi <= 1'b0;
            tx       <= '0;
            state    <= StData;
          end
        end
        StData: begin
          if (sck_fall && bit_cnt == 6'd31) begin
            rom_ack   <= 1'b1;
            rom_odata <= rx;
            state     <= StAck;
          end
        end
        StAck: begin
          if (STREAM_EN) begin
            state <= StStream;
          end else begin
            spi_ss <= 1'b1;
            state  <= StIdle;
          end
        end
        StStream: begin
          if (rom_stb) begin
            cur_addr <= rom_addr;
            bit_cnt  <= '0;
            if (hit) begin
              state <= StData;
            end else begin
              spi_ss <= 1'b1;
              state  <= StHold;
            end
          end
        end
        default: state <= StWakeCmd;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_flash_word_reader.sv
// Directed bench for spi_flash_word_reader with a behavioural READ-capable flash model.
module tb_spi_flash_word_reader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rom_stb = 1'b0;
  logic [21:0] rom_addr = '0;
  logic        rom_ack;
  logic [31:0] rom_odata;
  logic        rom_ready;
  logic        spi_ss, spi_sck, spi_mosi, spi_io2, spi_io3;
  logic        spi_miso = 1'b0;

  always #5 clk = ~clk;

  spi_flash_word_reader dut (
    .clk       (clk),
    .rst       (rst),
    .rom_stb   (rom_stb),
    .rom_addr  (rom_addr),
    .rom_ack   (rom_ack),
    .rom_odata (rom_odata),
    .rom_ready (rom_ready),
    .spi_ss    (spi_ss),
    .spi_sck   (spi_sck),
    .spi_mosi  (spi_mosi),
    .spi_miso  (spi_miso),
    .spi_io2   (spi_io2),
    .spi_io3   (spi_io3)
  );

  int checks = 0;
  int passed = 0;

  // Bus-side monitor.
  int          ack_cnt = 0;
  logic [31:0] last_data = '0;
  int          high_len = 0;
  int          last_high_len = 0;
  always @(negedge clk) begin
    if (rom_ack) begin
      ack_cnt++;
      last_data = rom_odata;
    end
    if (spi_ss) high_len++;
    else if (high_len != 0) begin
      last_high_len = high_len;
      high_len = 0;
    end
  end

  // Flash model: a session starts on ss falling; mosi captured on sck rise.
  int          sess_cnt = 0;
  int          nbits = 0;
  int          total_sck = 0;
  logic [31:0] hdr = '0;
  logic [7:0]  byte0 = '0;
  logic [23:0] faddr = '0;

  function automatic logic [7:0] mem_byte(input logic [23:0] a);
    case (a)
      24'h100000: mem_byte = 8'hDE;
      24'h100001: mem_byte = 8'hAD;
      24'h100002: mem_byte = 8'hBE;
      24'h100003: mem_byte = 8'hEF;
      24'h100004: mem_byte = 8'h01;
      24'h100005: mem_byte = 8'h23;
      24'h100006: mem_byte = 8'h45;
      24'h100007: mem_byte = 8'h67;
      default:    mem_byte = a[7:0] ^ 8'h5A;
    endcase
  endfunction

  always @(posedge spi_sck or negedge spi_ss) begin
    if (!spi_sck) begin
      sess_cnt++;
      nbits = 0;
      hdr = '0;
    end else begin
      total_sck++;
      if (nbits < 32) hdr = {hdr[30:0], spi_mosi};
      nbits++;
      if (nbits == 8) byte0 = hdr[7:0];
      if (nbits == 32) faddr = hdr[23:0];
    end
  end

  always @(negedge spi_sck) begin : drive_miso
    logic [7:0] b;
    if (nbits >= 32 && hdr[31:24] == 8'h03) begin
      b = mem_byte(faddr + 24'((nbits - 32) / 8));
      spi_miso <= b[7 - ((nbits - 32) % 8)];
    end else begin
      spi_miso <= 1'b0;
    end
  end

  task automatic req(input logic [21:0] a);
    @(negedge clk);
    rom_stb  = 1'b1;
    rom_addr = a;
    @(negedge clk);
    rom_stb  = 1'b0;
  endtask

  // lat = -1 when the budget expires without an ack.
  task automatic wait_ack(input int budget, output int lat);
    int start;
    start = ack_cnt;
    lat = 0;
    while (ack_cnt == start && lat < budget) begin
      @(negedge clk);
      #1;
      lat++;
    end
    if (ack_cnt == start) lat = -1;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks++; if (spi_ss !== 1'b1) $display("FAIL reset_ss: got %b want 1", spi_ss); else passed++;
    checks++; if (spi_sck !== 1'b0) $display("FAIL reset_sck: got %b want 0", spi_sck); else passed++;
    checks++; if (spi_mosi !== 1'b0) $display("FAIL reset_mosi: got %b want 0", spi_mosi); else passed++;
    checks++; if (rom_ack !== 1'b0) $display("FAIL reset_ack: got %b want 0", rom_ack); else passed++;
    checks++;
    if (rom_odata !== 32'h0) $display("FAIL reset_odata: got %h want 0", rom_odata);
    else passed++;
    checks++;
    if (rom_ready !== 1'b0) $display("FAIL reset_ready: got %b want 0", rom_ready);
    else passed++;
    checks++;
    if ({spi_io2, spi_io3} !== 2'b11) $display("FAIL io23: got %b want 11", {spi_io2, spi_io3});
    else passed++;
  endtask

  task automatic test_wake;
    int cyc;
    @(negedge clk);
    rst = 1'b1;
    cyc = 0;
    while (!rom_ready && cyc < 1200) begin
      rom_stb  = (cyc == 5 || cyc == 100);
      rom_addr = 22'h040000;
      @(negedge clk);
      cyc++;
    end
    rom_stb = 1'b0;
    checks++;
    if (cyc < 1050 || cyc > 1065) $display("FAIL wake_ready_time: got %0d want 1050..1065", cyc);
    else passed++;
    checks++; if (byte0 !== 8'hAB) $display("FAIL wake_cmd: got %h want ab", byte0); else passed++;
    checks++; if (total_sck != 8) $display("FAIL wake_sck: got %0d want 8", total_sck); else passed++;
    checks++; if (spi_ss !== 1'b1) $display("FAIL wake_ss: got %b want 1", spi_ss); else passed++;
    repeat (10) @(negedge clk);
    checks++; if (ack_cnt != 0) $display("FAIL wake_drop: got %0d want 0", ack_cnt); else passed++;
  endtask

  task automatic test_cold;
    int lat;
    req(22'h040000);
    wait_ack(300, lat);
    checks++;
    if (lat < 0 || lat > 270) $display("FAIL cold_latency: got %0d want 0..270", lat);
    else passed++;
    checks++;
    if (last_data !== 32'hDEADBEEF) $display("FAIL cold_data: got %h want deadbeef", last_data);
    else passed++;
    checks++;
    if (hdr !== 32'h03100000) $display("FAIL cold_hdr: got %h want 03100000", hdr);
    else passed++;
    checks++; if (sess_cnt != 2) $display("FAIL cold_sess: got %0d want 2", sess_cnt); else passed++;
    repeat (5) @(negedge clk);
    checks++; if (spi_ss !== 1'b0) $display("FAIL cold_ss_low: got %b want 0", spi_ss); else passed++;
    checks++; if (ack_cnt != 1) $display("FAIL cold_acks: got %0d want 1", ack_cnt); else passed++;
  endtask

  task automatic test_stream;
    int lat, sck0, sess0;
    sck0 = total_sck;
    sess0 = sess_cnt;
    req(22'h040001);
    wait_ack(200, lat);
    checks++;
    if (lat < 0 || lat > 131) $display("FAIL hit_latency: got %0d want 0..131", lat);
    else passed++;
    checks++;
    if (last_data !== 32'h01234567) $display("FAIL hit_data: got %h want 01234567", last_data);
    else passed++;
    checks++;
    if (total_sck - sck0 != 32) $display("FAIL hit_sck: got %0d want 32", total_sck - sck0);
    else passed++;
    checks++;
    if (sess_cnt != sess0) $display("FAIL hit_sess: got %0d want %0d", sess_cnt, sess0);
    else passed++;
  endtask

  task automatic test_miss;
    int lat, sess0;
    sess0 = sess_cnt;
    req(22'h000010);
    wait_ack(300, lat);
    checks++; if (lat < 0) $display("FAIL miss_ack: got timeout want ack"); else passed++;
    checks++;
    if (last_data !== 32'h1A1B1819) $display("FAIL miss_data: got %h want 1a1b1819", last_data);
    else passed++;
    checks++;
    if (hdr !== 32'h03000040) $display("FAIL miss_hdr: got %h want 03000040", hdr);
    else passed++;
    checks++;
    if (sess_cnt != sess0 + 1) $display("FAIL miss_sess: got %0d want %0d", sess_cnt, sess0 + 1);
    else passed++;
    checks++;
    if (last_high_len < 8) $display("FAIL miss_cs_high: got %0d want >=8", last_high_len);
    else passed++;
  endtask

  task automatic test_wrap;
    int lat, sess0, acks0;
    req(22'h3FFFFF);
    wait_ack(300, lat);
    checks++;
    if (last_data !== 32'hA6A7A4A5) $display("FAIL top_data: got %h want a6a7a4a5", last_data);
    else passed++;
    checks++;
    if (hdr !== 32'h03FFFFFC) $display("FAIL top_hdr: got %h want 03fffffc", hdr);
    else passed++;
    sess0 = sess_cnt;
    acks0 = ack_cnt;
    req(22'h000000);
    lat = 0;
    while (ack_cnt == acks0 && lat < 300) begin
      rom_stb  = (lat == 180 || lat == 220);
      rom_addr = 22'h000001;
      @(negedge clk);
      #1;
      lat++;
    end
    rom_stb = 1'b0;
    checks++;
    if (sess_cnt != sess0 + 1) $display("FAIL wrap_miss: got %0d want %0d", sess_cnt, sess0 + 1);
    else passed++;
    checks++;
    if (hdr !== 32'h03000000) $display("FAIL wrap_hdr: got %h want 03000000", hdr);
    else passed++;
    checks++;
    if (last_data !== 32'h5A5B5859) $display("FAIL wrap_data: got %h want 5a5b5859", last_data);
    else passed++;
    repeat (300) @(negedge clk);
    checks++;
    if (ack_cnt != acks0 + 1) $display("FAIL data_stb_drop: got %0d want %0d", ack_cnt, acks0 + 1);
    else passed++;
    sess0 = sess_cnt;
    req(22'h000000);
    wait_ack(300, lat);
    checks++;
    if (sess_cnt != sess0 + 1) $display("FAIL same_miss: got %0d want %0d", sess_cnt, sess0 + 1);
    else passed++;
    checks++;
    if (last_data !== 32'h5A5B5859) $display("FAIL same_data: got %h want 5a5b5859", last_data);
    else passed++;
  endtask

  task automatic test_reset_mid;
    int acks0, sess0, cyc;
    acks0 = ack_cnt;
    req(22'h000001);
    repeat (40) @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (spi_ss !== 1'b1) $display("FAIL rst_mid_ss: got %b want 1", spi_ss); else passed++;
    checks++; if (spi_sck !== 1'b0) $display("FAIL rst_mid_sck: got %b want 0", spi_sck); else passed++;
    repeat (20) @(negedge clk);
    sess0 = sess_cnt;
    rst = 1'b1;
    cyc = 0;
    while (nbits < 8 && cyc < 100 || sess_cnt == sess0 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    repeat (4) @(negedge clk);
    checks++;
    if (byte0 !== 8'hAB) $display("FAIL rst_rewake: got %h want ab", byte0); else passed++;
    checks++;
    if (ack_cnt != acks0) $display("FAIL rst_no_ack: got %0d want %0d", ack_cnt, acks0);
    else passed++;
    checks++;
    if (rom_ready !== 1'b0) $display("FAIL rst_ready: got %b want 0", rom_ready); else passed++;
    checks++; if (ack_cnt != 6) $display("FAIL total_acks: got %0d want 6", ack_cnt); else passed++;
  endtask

  initial begin
    test_reset;
    test_wake;
    test_cold;
    test_stream;
    test_miss;
    test_wrap;
    test_reset_mid;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
